// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes, the ID/EX
// bundle and the forwarding match helper.
package pipe_defs;

  localparam int DW = 32;  // datapath width
  localparam int RW = 5;   // register-number width

  // Canonical ALU codes. Several ops ignore aluc[3]; the decoder in
  // pipe_alu treats those bits as don't-care.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [3:0]    aluc;
    logic          shift;
    logic          aluimm;
    logic [RW-1:0] wn;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] imm;
  } idex_t;

  // A later stage supplies a source operand when it writes a nonzero
  // register equal to that source. r0 is hardwired zero, never forwarded.
  function automatic logic fwd_hit(input logic wreg, input logic [RW-1:0] wn,
                                   input logic [RW-1:0] src);
    return wreg && (wn != '0) && (wn == src);
  endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU shared by the pipelined EX stage and the single-cycle CPU.
//   a, b  : operands (a supplies the shift amount for shift ops)
//   aluc  : op code (see pipe_defs ALU_* constants)
//   r     : result, modulo 2^DW, no overflow trap
//   z     : r == 0
module pipe_alu #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    aluc,
  output logic [DW-1:0] r,
  output logic          z
);

  localparam int SHW = $clog2(DW);

  // Only the low bits of a form the shift amount; the rest are ignored.
  logic [SHW-1:0] sh;
  assign sh = a[SHW-1:0];

  // aluc[1:0] picks the group, aluc[2] the op within it. aluc[3] only
  // matters for right shifts (arithmetic vs logical); 1011 falls to SLL.
  always_comb begin
    r = '0;
    unique case (aluc[1:0])
      2'b00:   r = aluc[2] ? (a - b) : (a + b);
      2'b01:   r = aluc[2] ? (a | b) : (a & b);
      2'b10:   r = aluc[2] ? (b << 16) : (a ^ b);
      default: begin
        if (!aluc[2])     r = b << sh;
        else if (aluc[3]) r = $signed(b) >>> sh;
        else              r = b >> sh;
      end
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage of the 5-stage pipeline.
//   clk, clrn        : clock, synchronous active-high clear of ID/EX
//   stall, flush     : hazard-unit hold / bubble insert (flush wins)
//   ID*              : decoded instruction entering ID/EX
//   MEM*, WB*        : later-stage write info used for operand forwarding
//   EXwreg..EXwn     : registered control/destination toward EX/MEM
//   EXalu, EXz       : ALU result and zero flag (combinational)
//   EXstore          : forwarded operand B, used as store data
//   EXvalid          : ID/EX holds a real instruction
// DW/RW must match the widths in pipe_defs, which sizes the ID/EX bundle.
module pipe_ex_stage
  import pipe_defs::*;
#(
  parameter int DW = pipe_defs::DW,
  parameter int RW = pipe_defs::RW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          stall,
  input  logic          flush,
  input  logic          IDwreg,
  input  logic          IDm2reg,
  input  logic          IDwmem,
  input  logic [3:0]    IDaluc,
  input  logic          IDshift,
  input  logic          IDaluimm,
  input  logic [RW-1:0] IDwn,
  input  logic [RW-1:0] IDrs,
  input  logic [RW-1:0] IDrt,
  input  logic [DW-1:0] IDqa,
  input  logic [DW-1:0] IDqb,
  input  logic [DW-1:0] IDimmeOrSa,
  input  logic          MEMwreg,
  input  logic          MEMm2reg,
  input  logic [RW-1:0] MEMwn,
  input  logic [DW-1:0] MEMalu,
  input  logic          WBwreg,
  input  logic [RW-1:0] WBwn,
  input  logic [DW-1:0] WBdata,
  output logic          EXwreg,
  output logic          EXm2reg,
  output logic          EXwmem,
  output logic [RW-1:0] EXwn,
  output logic [DW-1:0] EXalu,
  output logic [DW-1:0] EXstore,
  output logic          EXz,
  output logic          EXvalid
);

  idex_t id_bus, idex;

  assign id_bus = '{valid: 1'b1, wreg: IDwreg, m2reg: IDm2reg, wmem: IDwmem,
                    aluc: IDaluc, shift: IDshift, aluimm: IDaluimm,
                    wn: IDwn, rs: IDrs, rt: IDrt,
                    qa: IDqa, qb: IDqb, imm: IDimmeOrSa};

  // A bubble is the all-zero bundle: no writes, valid=0, and an ADD of
  // 0+0 so EXz reads 1.
  always_ff @(posedge clk) begin
    if (clrn)        idex <= '0;
    else if (flush)  idex <= '0;
    else if (!stall) idex <= id_bus;
  end

  // Forwarding is evaluated every cycle, so a stalled instruction keeps
  // picking up fresh MEM/WB results. A load in MEM has no data yet and is
  // skipped; the hazard unit stalls for that case.
  logic          mem_fwd_ok;
  logic [DW-1:0] fwd_a, fwd_b, op_a, op_b;

  assign mem_fwd_ok = MEMwreg && !MEMm2reg;

  always_comb begin
    fwd_a = idex.qa;
    if (fwd_hit(mem_fwd_ok, MEMwn, idex.rs))  fwd_a = MEMalu;
    else if (fwd_hit(WBwreg, WBwn, idex.rs))  fwd_a = WBdata;
  end

  always_comb begin
    fwd_b = idex.qb;
    if (fwd_hit(mem_fwd_ok, MEMwn, idex.rt))  fwd_b = MEMalu;
    else if (fwd_hit(WBwreg, WBwn, idex.rt))  fwd_b = WBdata;
  end

  assign op_a = idex.shift  ? idex.imm : fwd_a;
  assign op_b = idex.aluimm ? idex.imm : fwd_b;

  pipe_alu #(.DW(DW)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .aluc (idex.aluc),
    .r    (EXalu),
    .z    (EXz)
  );

  assign EXstore = fwd_b;
  assign EXwreg  = idex.wreg;
  assign EXm2reg = idex.m2reg;
  assign EXwmem  = idex.wmem;
  assign EXwn    = idex.wn;
  assign EXvalid = idex.valid;

endmodule

// File: doc/pipe_ex_stage.md
Name: pipe_ex_stage

Overview:
Execute stage of the 5-stage pipeline, directly downstream of the ID stage.
- Owns the ID/EX pipeline register.
- Forwards operands from the MEM and WB stages, performs the ALU operation, and presents results combinationally to the EX/MEM register.
- Supports stall (hold) and flush (bubble insert) from the hazard unit.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clk  in  1  pipeline clock, all state on rising edge
clrn  in  1  reset; synchronous, active-high: when 1 at a rising clk edge, ID/EX register cleared
stall  in  1  hold ID/EX contents this edge
flush  in  1  load a bubble into ID/EX this edge
IDwreg  in  1  register-write enable from decode
IDm2reg  in  1  load (result from memory)
IDwmem  in  1  store
IDaluc  in  4  ALU op code
IDshift  in  1  operand A = IDimmeOrSa (shift amount)
IDaluimm  in  1  operand B = IDimmeOrSa
IDwn  in  RW  destination register
IDrs  in  RW  source register A number
IDrt  in  RW  source register B number
IDqa  in  DW  register-file read A
IDqb  in  DW  register-file read B
IDimmeOrSa  in  DW  extended immediate or zero-extended sa
MEMwreg  in  1  MEM-stage write enable
MEMm2reg  in  1  MEM-stage instruction is a load
MEMwn  in  RW  MEM-stage destination
MEMalu  in  DW  MEM-stage ALU result
WBwreg  in  1  WB write enable
WBwn  in  RW  WB destination
WBdata  in  DW  WB write data
EXwreg  out  1  registered IDwreg
EXm2reg  out  1  registered IDm2reg
EXwmem  out  1  registered IDwmem
EXwn  out  RW  registered IDwn
EXalu  out  DW  ALU result
EXstore  out  DW  forwarded operand B (store data)
EXz  out  1  EXalu == 0
EXvalid  out  1  ID/EX holds a real instruction (not bubble)

Behaviour:
- ID/EX register: captures all ID* inputs plus valid=1 on rising clk.
- Priority of control at a clk edge: clrn > flush > stall > load.
- clrn=1 at the edge: all fields 0, valid=0.
  - Result: EXwreg = EXm2reg = EXwmem = 0, EXwn = 0, EXvalid = 0.
  - EXalu = 0 (aluc 0 = ADD, 0+0), EXz = 1.
  - Reset mid-stream discards the in-flight instruction.
- flush=1: control fields wreg/m2reg/wmem and valid cleared; data fields don't-care but loaded as 0. Flush overrides stall.
- stall=1 (no flush): register unchanged. Forwarding is re-evaluated each cycle, so held operands pick up new MEM/WB values.
- Latency: ID values present at edge N produce EX outputs combinationally during cycle N+1. No internal multi-cycle ops.
- Forwarding, per operand (A uses rs/qa, B uses rt/qb):
  - If MEMwreg & !MEMm2reg & MEMwn != 0 & MEMwn == src: take MEMalu.
  - Else if WBwreg & WBwn != 0 & WBwn == src: take WBdata.
  - Else take the registered qa/qb.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
  - MEM-stage load match is not forwarded; load-use stall is the upstream hazard unit's duty.
- Operand select:
  - A = shift ? immeOrSa : fwdA.
  - B = aluimm ? immeOrSa : fwdB.
  - EXstore = fwdB, always, independent of aluimm.
- aluc encoding (x = don't care):
  - x000 ADD, A+B, mod 2^32, no overflow trap.
  - x100 SUB, A−B.
  - x001 AND.
  - x101 OR.
  - x010 XOR.
  - x110 LUI, B<<16.
  - 0011 SLL, B << A[4:0].
  - 0111 SRL, logical B >> A[4:0].
  - 1111 SRA, arithmetic B >>> A[4:0].
  - 1011 is unused and yields SLL.
- Shift amount uses only A[4:0]; upper bits ignored.
- EXz is computed from EXalu in all states, including bubbles.

Decomposition:
- Shared package pipe_defs: ALU op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA), DW/RW widths, and the ID/EX bundle typedef.
- One sub-module, pipe_alu: combinational, (a, b, aluc) -> (r, z). It is reused by the single-cycle CPU.
- Forwarding muxes stay inline.

Test Plan:
1. Reset with garbage on ID*, clrn=1 for 2 edges → EXwreg=0, EXwmem=0, EXvalid=0, EXalu=0, EXz=1.
2. ADD, qa=5, qb=0xFFFFFFFB, no forwarding → EXalu=0, EXz=1. SUB with qa=3, qb=5 → 0xFFFFFFFE.
3. SRA, shift=1, sa=4, qb=0x80000000 → 0xF8000000. SRL on the same operands → 0x08000000. LUI, imm=0x1234 → 0x12340000.
4. rs=7, MEMwreg=1, MEMwn=7, MEMalu=0xAA, and WBwreg=1, WBwn=7, WBdata=0xBB → MEM wins, A=0xAA. Drop MEMwreg → A=0xBB. Set rs=0 with WBwn=0 → uses qa.
5. MEMm2reg=1 with MEMwn=rt → no MEM forward; WB or qb value used. Store with aluimm=1, rt forwarded from WB=0x55 → EXstore=0x55.
6. stall held 3 edges while WBdata changes → EXwn/EXwreg unchanged and EXalu tracks the new WBdata. flush with stall both 1 → EXwreg=0, EXwmem=0, EXvalid=0 next cycle.
